// File: rtl/param_pkg.sv
// Shared types for the parameter-streaming engine: build defaults, FSM state
// encoding and the per-beat tag carried alongside each weight word.
package param_pkg;

  localparam int PARSIZE_DEF = 16;
  localparam int WVEC_DEF    = 9;
  localparam int TAG_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [TAG_CNT_W-1:0] o;
    logic [TAG_CNT_W-1:0] i;
    logic                 first_i;
    logic                 last_i;
    logic                 last;
  } beat_tag_t;

endpackage

// File: rtl/param_fifo2.sv
// Two-entry FIFO with occupancy output. The caller guarantees it never pushes
// when full or pops when empty.
module param_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= din;
        else        mem0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = rd_ptr ? mem1 : mem0;

endmodule

// File: rtl/param_fetch.sv
// Weight/bias streaming engine: walks o x i over the weight ROM and emits beats
// on a valid/ready stream. Bias path is built only with PARAM_FETCH_BIAS_EN.
module param_fetch
  import param_pkg::*;
#(
  parameter int PARSIZE = PARSIZE_DEF,
  parameter int WVEC    = WVEC_DEF,
  parameter int ADDR_W  = 16,
  parameter int BADDR_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       w_base,
  input  logic [ADDR_W-1:0]       pitch,
  input  logic [CNT_W-1:0]        n_out,
  input  logic [CNT_W-1:0]        n_in,
  input  logic [BADDR_W-1:0]      b_base,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [WVEC*PARSIZE-1:0] mem_data,
  output logic [BADDR_W-1:0]      bias_addr,
  input  logic [PARSIZE-1:0]      bias_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WVEC*PARSIZE-1:0] out_w,
  output logic [PARSIZE-1:0]      out_b,
  output logic [CNT_W-1:0]        out_o,
  output logic [CNT_W-1:0]        out_i,
  output logic                    out_first_i,
  output logic                    out_last_i,
  output logic                    out_last,
  output logic [1:0]              dbg_state
);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // once out_valid rises it and the payload hold until that transfer.
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam int DW = WVEC * PARSIZE;
  localparam int TW = $bits(beat_tag_t);
`ifdef PARAM_FETCH_BIAS_EN
  localparam int EW = DW + TW + PARSIZE;
`else
  localparam int EW = DW + TW;
`endif

  logic [1:0]        state;
  logic [CNT_W-1:0]  o_cnt, i_cnt, n_out_q, n_in_q;
  logic [ADDR_W-1:0] row_addr, pitch_q;
  logic              infl;
  beat_tag_t         tag_q, new_tag, head_tag;
  logic              issue, last_i_now, last_o_now, fifo_empty, push, pop;
  logic [1:0]        fifo_count;
  logic [EW-1:0]     live_entry, fifo_dout, head;
  logic [DW-1:0]     head_w;

  assign last_i_now = (i_cnt == n_in_q - CNT_W'(1));
  assign last_o_now = (o_cnt == n_out_q - CNT_W'(1));
  // Reads in flight plus buffered beats never exceed the FIFO depth.
  assign issue      = (state == ST_RUN) && ((fifo_count + {1'b0, infl}) < 2'd2);

  assign mem_en   = issue;
  assign mem_addr = row_addr + ADDR_W'(i_cnt);

  assign new_tag.o       = TAG_CNT_W'(o_cnt);
  assign new_tag.i       = TAG_CNT_W'(i_cnt);
  assign new_tag.first_i = (i_cnt == '0);
  assign new_tag.last_i  = last_i_now;
  assign new_tag.last    = last_i_now && last_o_now;

`ifdef PARAM_FETCH_BIAS_EN
  logic [BADDR_W-1:0] b_base_q;
  logic [PARSIZE-1:0] bias_q;
  assign bias_addr  = b_base_q + BADDR_W'(o_cnt);
  assign live_entry = {mem_data, tag_q, bias_q};
`else
  logic unused_bias;
  assign unused_bias = ^{bias_data, b_base};
  assign bias_addr   = '0;
  assign live_entry  = {mem_data, tag_q};
`endif

  // Fall-through: with the FIFO empty, the ROM word is presented the cycle it arrives.
  assign fifo_empty = (fifo_count == 2'd0);
  assign out_valid  = !fifo_empty || infl;
  assign pop        = !fifo_empty && out_ready;
  assign push       = infl && !(fifo_empty && out_ready);
  assign head       = fifo_empty ? live_entry : fifo_dout;
  assign head_w     = head[EW-1 -: DW];
  assign head_tag   = head[EW-DW-1 -: TW];

  param_fifo2 #(.W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (live_entry),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_comb begin
    out_w       = '0;
    out_b       = '0;
    out_o       = '0;
    out_i       = '0;
    out_first_i = 1'b0;
    out_last_i  = 1'b0;
    out_last    = 1'b0;
    if (out_valid) begin
      out_w       = head_w;
`ifdef PARAM_FETCH_BIAS_EN
      out_b       = head[PARSIZE-1:0];
`endif
      out_o       = CNT_W'(head_tag.o);
      out_i       = CNT_W'(head_tag.i);
      out_first_i = head_tag.first_i;
      out_last_i  = head_tag.last_i;
      out_last    = head_tag.last;
    end
  end

  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      o_cnt    <= '0;
      i_cnt    <= '0;
      n_out_q  <= '0;
      n_in_q   <= '0;
      row_addr <= '0;
      pitch_q  <= '0;
      infl     <= 1'b0;
      tag_q    <= '0;
`ifdef PARAM_FETCH_BIAS_EN
      b_base_q <= '0;
      bias_q   <= '0;
`endif
    end else begin
      infl <= issue;
      if (issue) begin
        tag_q <= new_tag;
`ifdef PARAM_FETCH_BIAS_EN
        bias_q <= bias_data;
`endif
        if (last_i_now) begin
          i_cnt    <= '0;
          o_cnt    <= o_cnt + CNT_W'(1);
          row_addr <= row_addr + pitch_q;
        end else begin
          i_cnt <= i_cnt + CNT_W'(1);
        end
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (n_out != '0 && n_in != '0) begin
              state    <= ST_RUN;
              n_out_q  <= n_out;
              n_in_q   <= n_in;
              pitch_q  <= pitch;
              row_addr <= w_base;
              o_cnt    <= '0;
              i_cnt    <= '0;
`ifdef PARAM_FETCH_BIAS_EN
              b_base_q <= b_base;
`endif
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN:   if (issue && last_i_now && last_o_now) state <= ST_DRAIN;
        ST_DRAIN: if (out_valid && out_ready && head_tag.last) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_fetch.sv
// Directed bench for param_fetch: ROM/bias models, scoreboard queues for read
// addresses and beats, a negedge monitor, and timing checks per layer run.
module tb_param_fetch;

  localparam int DW = 144;
  localparam int BW = 179;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       w_base = '0, pitch = '0;
  logic [7:0]        n_out = '0, n_in = '0, b_base = '0;
  logic              busy, done, mem_en, out_valid, out_first_i, out_last_i, out_last;
  logic              out_ready = 1'b1;
  logic [15:0]       mem_addr, bias_data, out_b;
  logic [7:0]        bias_addr, out_o, out_i;
  logic [DW-1:0]     mem_data, out_w;
  logic [1:0]        dbg_state;

  logic [BW-1:0]     exp_q[$];
  logic [23:0]       addr_q[$];

  int checks = 0, errors = 0, cyc = 0, rdy_mode = 0, rc = 0;
  int iss = 0, acc = 0, vld_cnt = 0, run_ni = 0;
  bit first_en_set = 0, first_val_set = 0, stalled = 0;
  int first_en_cyc = 0, first_val_cyc = 0;
  logic [15:0] first_addr, last_addr, row1_addr;
  logic [BW-1:0] hold, cur;

  param_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_base(w_base), .pitch(pitch),
    .n_out(n_out), .n_in(n_in), .b_base(b_base), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .bias_addr(bias_addr), .bias_data(bias_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_w(out_w), .out_b(out_b), .out_o(out_o),
    .out_i(out_i), .out_first_i(out_first_i), .out_last_i(out_last_i),
    .out_last(out_last), .dbg_state(dbg_state)
  );

  // clock / reset / memory models
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_word(input logic [15:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < 9; k++) r[k*16 +: 16] = a + 16'(k * 4099);
    return r;
  endfunction

  always @(posedge clk) if (mem_en) mem_data <= rom_word(mem_addr);
  assign bias_data = 16'hB000 | {8'h00, bias_addr};

  initial forever begin
    @(posedge clk);
    #1;
    rc++;
    out_ready = (rdy_mode == 0) ? 1'b1 : ((rc % 4 == 0) || (rc % 4 == 3));
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // expected-response generation
  task automatic push_layer(input logic [15:0] wb, input logic [15:0] pit,
                            input logic [7:0] no, input logic [7:0] ni, input logic [7:0] bb);
    logic [15:0] a, b;
    logic [7:0]  ba;
    for (int o = 0; o < int'(no); o++) begin
      for (int i = 0; i < int'(ni); i++) begin
        a = 16'(int'(wb) + o * int'(pit) + i);
`ifdef PARAM_FETCH_BIAS_EN
        ba = 8'(int'(bb) + o);
        b  = 16'hB000 | {8'h00, ba};
`else
        ba = 8'h00;
        b  = 16'h0000;
`endif
        addr_q.push_back({a, ba});
        exp_q.push_back({rom_word(a), b, 8'(o), 8'(i), i == 0, i == int'(ni) - 1,
                         (i == int'(ni) - 1) && (o == int'(no) - 1)});
      end
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        iss++;
        if (!first_en_set) begin
          first_en_set = 1;
          first_en_cyc = cyc + 1;
          first_addr   = mem_addr;
        end
        last_addr = mem_addr;
        if (iss == run_ni + 1) row1_addr = mem_addr;
        chk("outstanding_le2", 256'(iss - acc <= 2), 256'(1));
        chk("issue_expected", 256'(addr_q.size() != 0), 256'(1));
        if (addr_q.size() != 0) chk("mem_bias_addr", 256'({mem_addr, bias_addr}), 256'(addr_q.pop_front()));
      end
      cur = {out_w, out_b, out_o, out_i, out_first_i, out_last_i, out_last};
      if (out_valid) begin
        vld_cnt++;
        if (!first_val_set) begin
          first_val_set = 1;
          first_val_cyc = cyc + 1;
        end
        if (stalled) chk("stall_stable", 256'(cur), 256'(hold));
        if (out_ready) begin
          chk("beat_expected", 256'(exp_q.size() != 0), 256'(1));
          if (exp_q.size() != 0) chk("beat", 256'(cur), 256'(exp_q.pop_front()));
          acc++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold = cur;
        end
      end else if (stalled) begin
        chk("stall_valid", 256'(out_valid), 256'(1));
        stalled = 0;
      end
    end
  end

  function automatic logic [255:0] all_outs();
    return 256'({busy, done, mem_en, mem_addr, bias_addr, out_valid, out_w, out_b,
                 out_o, out_i, out_first_i, out_last_i, out_last, dbg_state});
  endfunction

  task automatic issue_start(input logic [15:0] wb, input logic [15:0] pit,
                             input logic [7:0] no, input logic [7:0] ni, input logic [7:0] bb,
                             output int t);
    push_layer(wb, pit, no, ni, bb);
    @(posedge clk);
    #1;
    iss = 0; acc = 0; vld_cnt = 0; first_en_set = 0; first_val_set = 0; run_ni = int'(ni);
    w_base = wb; pitch = pit; n_out = no; n_in = ni; b_base = bb;
    start = 1'b1;
    t = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // one layer run; exp_done < 0 skips the done-cycle check, exp_first < 0 skips address ends
  task automatic run(input logic [15:0] wb, input logic [15:0] pit, input logic [7:0] no,
                     input logic [7:0] ni, input logic [7:0] bb, input int exp_done,
                     input int exp_first, input int exp_last, input bit mid);
    int t, n;
    bit seen;
    issue_start(wb, pit, no, ni, bb, t);
    seen = 0;
    for (n = 0; n < 20000 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        if (exp_done >= 0) chk("done_cycle", 256'(cyc + 1 - t), 256'(exp_done));
        chk("busy_low_at_done", 256'(busy), 256'(0));
      end
      if (mid && n == 2) begin
        start = 1'b1; w_base = 16'h1234; pitch = 16'd7; n_out = 8'd7; n_in = 8'd2;
      end
      if (mid && n == 3) start = 1'b0;
    end
    chk("done_seen", 256'(seen), 256'(1));
    chk("beats_left", 256'(exp_q.size()), 256'(0));
    chk("reads_left", 256'(addr_q.size()), 256'(0));
    chk("beats_accepted", 256'(acc), 256'(int'(no) * int'(ni)));
    if (int'(no) * int'(ni) != 0) begin
      chk("first_en_cycle", 256'(first_en_cyc - t), 256'(1));
      chk("first_valid_cycle", 256'(first_val_cyc - t), 256'(2));
    end else begin
      chk("zero_no_reads", 256'(iss), 256'(0));
      chk("zero_no_valid", 256'(vld_cnt), 256'(0));
    end
    if (exp_first >= 0) begin
      chk("first_addr", 256'(first_addr), 256'(exp_first));
      chk("last_addr", 256'(last_addr), 256'(exp_last));
    end
    @(negedge clk);
    chk("done_one_cycle", 256'(done), 256'(0));
  endtask

  initial begin : main
    int t, g;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 256'(0));

    // conv: 16 x 1, pitch 1
    run(16'd0, 16'd1, 8'd16, 8'd1, 8'd0, 18, 0, 15, 0);
    // dense 96 x 96, pitch 96
    run(16'd24576, 16'd96, 8'd96, 8'd96, 8'd96, 9218, 24576, 33791, 0);
    chk("dense_o1_i0_addr", 256'(row1_addr), 256'(24672));
    // backpressure 1,0,0,1
    rdy_mode = 1;
    run(16'd100, 16'd10, 8'd4, 8'd3, 8'd5, -1, 100, 132, 0);
    rdy_mode = 0;
    // zero count
    run(16'd0, 16'd1, 8'd5, 8'd0, 8'd0, 1, -1, -1, 0);
    // address wrap with ignored second start
    run(16'hFFFE, 16'd1, 8'd1, 8'd4, 8'd0, 6, 16'hFFFE, 16'h0001, 1);

    // reset after 5 beats of 16
    issue_start(16'd0, 16'd1, 8'd16, 8'd1, 8'd0, t);
    g = 0;
    while (acc < 5 && g < 200) begin
      @(posedge clk);
      g++;
    end
    chk("mid_reset_reached", 256'(acc >= 5), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", all_outs(), 256'(0));
    exp_q.delete();
    addr_q.delete();
    stalled = 0;
    repeat (2) @(negedge clk);
    chk("held_reset_outputs", all_outs(), 256'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run(16'd0, 16'd1, 8'd16, 8'd1, 8'd0, 18, 0, 15, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_fetch.md
# param_fetch

Parametrised parameter-streaming engine for the NN accelerator. For one layer it walks the weight memory over output channels × input slices using a runtime descriptor (base, counts, row pitch), absorbs the synchronous-ROM read latency, and delivers weight words, with the matching bias, on a valid/ready stream. It sits between the layer controller and the conv/dense MAC datapaths and replaces per-layer hard-coded address muxes.

## Interface
- PARSIZE, 16: bits per parameter.
- WVEC, 9: parameters per memory word (9 for 3×3 conv, 1 for dense).
- ADDR_W, 16: weight-memory address width.
- BADDR_W, 8: bias-memory address width.
- CNT_W, 8: width of the channel/slice counters.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches descriptor; ignored unless idle.
- w_base  in  ADDR_W  address of weight (o=0, i=0).
- pitch  in  ADDR_W  address step per output channel (e.g. 96 for 96-input dense).
- n_out  in  CNT_W  output channel count.
- n_in  in  CNT_W  input slices per output channel.
- b_base  in  BADDR_W  bias address of o=0.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- mem_en  out  1  weight-memory read enable.
- mem_addr  out  ADDR_W  weight-memory address.
- mem_data  in  WVEC*PARSIZE  read data, valid one cycle after mem_en.
- bias_addr  out  BADDR_W  combinational-read bias-memory address.
- bias_data  in  PARSIZE  bias read data, same cycle.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_w  out  WVEC*PARSIZE  weight word.
- out_b  out  PARSIZE  bias of out_o.
- out_o, out_i  out  CNT_W each  channel/slice indices of the beat.
- out_first_i, out_last_i  out  1 each  beat is i=0 / i=n_in-1.
- out_last  out  1  final beat of the layer.

## Operation
- FSM: IDLE → (start, n_out≠0, n_in≠0) RUN → (last read issued) DRAIN → (output FIFO empty) DONE → IDLE. DONE lasts one cycle and drives done=1.
- start with n_out=0 or n_in=0: IDLE → DONE directly; no reads, no beats.
- Address generation is incremental, with no multiplier: row_addr starts at w_base and adds pitch on each o increment; mem_addr = row_addr + i. All sums are mod 2^ADDR_W, with silent wrap.
- Issue order: i fastest, then o. Each issue carries its tags (o, i, first/last flags) through a one-stage tag pipe aligned with mem_data.
- 2-entry output FIFO, holding data + tags + bias. A read is issued only when FIFO occupancy + in-flight reads < 2. No beat is ever dropped under backpressure.
- bias_addr = b_base + o of the issuing read. bias_data is sampled at issue and stored with the tags.
- FIFO push and pop in the same cycle: occupancy is unchanged.
- start while busy: ignored, with no effect on the descriptor.

## Timing
- Reset values: busy=0, done=0, mem_en=0, mem_addr=0, bias_addr=0, out_valid=0, out_w=0, out_b=0, all indices and flags 0. FSM in IDLE, FIFO empty.
- Reset mid-run: every register is cleared immediately. A pending in-flight mem_data is discarded.
- start at edge t: first mem_en at cycle t+1. First out_valid at t+2.
- With out_ready held high: one beat per cycle. Last beat at t+1+n_out·n_in. done at the cycle after the last handshake.
- out_valid, once asserted, stays high with stable payload until out_ready.
- busy deasserts in the same cycle done pulses.

## Configuration
- PARAM_FETCH_BIAS_EN defined: bias path as above.
- PARAM_FETCH_BIAS_EN undefined: bias_addr is held 0, bias_data is unused, out_b=0, and no bias FIFO storage is built.

## Structure
- Shared package param_pkg holds PARSIZE/WVEC defaults, the FSM state enum (IDLE, RUN, DRAIN, DONE), and the beat tag struct (o, i, first_i, last_i, last).
- One sub-module: param_fifo2, a 2-entry FIFO with occupancy output, instantiated once for data+tags.

## Test plan
- Conv-style: w_base=0, pitch=1, n_out=16, n_in=1, WVEC=9, ready=1 → addresses 0..15 in consecutive cycles, 16 beats, out_last on o=15, done at t+18.
- Dense, non-power-of-two pitch: w_base=24576, pitch=96, n_out=96, n_in=96, b_base=96 → first addr 24576, last addr 33791. Beat (o=1,i=0) reads 24672. Bias address is 96+o.
- Backpressure: n_out=4, n_in=3, out_ready toggling 1,0,0,1 repeating → all 12 beats delivered in order, payload stable while stalled, at most 2 reads outstanding.
- Zero count: n_out=5, n_in=0 → no mem_en, no out_valid, done at t+1.
- Wrap and ignore: w_base=0xFFFE, pitch=1, n_out=1, n_in=4 → addresses FFFE, FFFF, 0000, 0001. A second start mid-run is ignored.
- Reset mid-run: rst_n low after 5 beats of 16 → all outputs 0 immediately. A new start then runs cleanly from (0,0).
